// File: rtl/execute_mdu_stage_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// exec_pkg : opcode/funct encodings, MDU op and stage FSM types
// Revision : 1.0
//------------------------------------------------------------------------------
package exec_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
  } mdu_op_e;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/execute_mdu_stage_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// execute_mdu_stage_if : issue-side inputs and retire-side outputs of the stage
// Revision : 1.0
//------------------------------------------------------------------------------
interface execute_mdu_stage_if #(parameter int XLEN = 32);
  logic            valid_in;
  logic            stall_in;
  logic            flush_in;
  logic [6:0]      alu_opcode_in;
  logic [2:0]      alu_funct3;
  logic [6:0]      alu_funct7;
  logic [XLEN-1:0] rs1_value_in;
  logic [XLEN-1:0] rs2_value_in;
  logic [XLEN-1:0] imm_value_in;
  logic [XLEN-1:0] pc_co_in;
  logic [4:0]      rd_in;
  logic            branch_predicted_taken_in;
  logic            ready_out;
  logic            valid_out;
  logic            rd_write;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result_out;
  logic            branch_taken_out;
  logic [XLEN-1:0] branch_pc_out;
  logic            mispredict_out;

  modport master (
    output valid_in, stall_in, flush_in, alu_opcode_in, alu_funct3, alu_funct7,
           rs1_value_in, rs2_value_in, imm_value_in, pc_co_in, rd_in,
           branch_predicted_taken_in,
    input  ready_out, valid_out, rd_write, rd_out, result_out,
           branch_taken_out, branch_pc_out, mispredict_out
  );

  modport slave (
    input  valid_in, stall_in, flush_in, alu_opcode_in, alu_funct3, alu_funct7,
           rs1_value_in, rs2_value_in, imm_value_in, pc_co_in, rd_in,
           branch_predicted_taken_in,
    output ready_out, valid_out, rd_write, rd_out, result_out,
           branch_taken_out, branch_pc_out, mispredict_out
  );
endinterface
`default_nettype wire

// File: rtl/execute_mdu_stage_divider.sv
`default_nettype none
//------------------------------------------------------------------------------
// exec_divider : iterative restoring divider, DIV_BITS quotient bits per cycle
// Revision : 1.0
//------------------------------------------------------------------------------
module exec_divider #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  input  logic            flush,
  input  logic            signed_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int ITERS = XLEN / DIV_BITS;
  localparam int CW    = $clog2(ITERS + 1);

  logic            busy, neg_q, neg_r, div_zero;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo, rem, dsr, dvd_orig;
  logic [XLEN:0]   part_rem;
  logic [XLEN-1:0] part_quo;
  logic            a_neg, b_neg;

  assign a_neg = signed_op & dividend[XLEN-1];
  assign b_neg = signed_op & divisor[XLEN-1];

  // quo doubles as the shift register feeding dividend bits into the remainder
  always_comb begin
    part_rem = {1'b0, rem};
    part_quo = quo;
    for (int i = 0; i < DIV_BITS; i++) begin
      part_rem = {part_rem[XLEN-1:0], part_quo[XLEN-1]};
      part_quo = {part_quo[XLEN-2:0], 1'b0};
      if (part_rem >= {1'b0, dsr}) begin
        part_rem    = part_rem - {1'b0, dsr};
        part_quo[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= CW'(ITERS);
      quo      <= a_neg ? -dividend : dividend;
      dsr      <= b_neg ? -divisor : divisor;
      rem      <= '0;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (divisor == '0);
      dvd_orig <= dividend;
    end else if (!stall && busy) begin
      if (cnt != '0) begin
        quo <= part_quo;
        rem <= part_rem[XLEN-1:0];
        cnt <= cnt - CW'(1);
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done      = busy && (cnt == '0);
  assign quotient  = div_zero ? '1 : (neg_q ? -quo : quo);
  assign remainder = div_zero ? dvd_orig : (neg_r ? -rem : rem);

endmodule
`default_nettype wire

// File: rtl/execute_mdu_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// execute_mdu_stage : RV execute stage, ALU/branch plus multi-cycle RV32M MDU
// Revision : 1.0
//------------------------------------------------------------------------------
module execute_mdu_stage
  import exec_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1,
  parameter int ENABLE_M   = 1
) (
  input  logic                req,
  input  logic                reset,
  execute_mdu_stage_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  fsm_state_e      state, state_n;
  logic            accept, is_m, m_go, mul_go, div_go, div_done;
  logic [XLEN-1:0] rs1, rs2, imm, pc, pc4, op_b, alu_res, br_target, m_result;
  logic [XLEN-1:0] quotient, remainder;
  logic [SHW-1:0]  shamt;
  logic            alu_wr, is_br, br_taken, a_sgn, b_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod, mul_out;
  logic [2*XLEN-1:0] mul_pipe [MUL_STAGES];
  logic [MUL_STAGES-1:0] mul_vld;
  mdu_op_e         m_op;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_pc4;

  assign rs1    = bus.rs1_value_in;
  assign rs2    = bus.rs2_value_in;
  assign imm    = bus.imm_value_in;
  assign pc     = bus.pc_co_in;
  assign pc4    = pc + XLEN'(4);
  assign accept = bus.valid_in & bus.ready_out & ~bus.stall_in & ~bus.flush_in;
  assign is_m   = (bus.alu_opcode_in == OPC_OP) && (bus.alu_funct7 == F7_MULDIV);
  assign m_go   = accept & is_m & (ENABLE_M != 0);
  assign mul_go = m_go & ~bus.alu_funct3[2];
  assign div_go = m_go & bus.alu_funct3[2];

  always_comb begin
    op_b      = (bus.alu_opcode_in == OPC_OP) ? rs2 : imm;
    shamt     = op_b[SHW-1:0];
    alu_res   = '0;
    alu_wr    = 1'b0;
    is_br     = 1'b0;
    br_taken  = 1'b0;
    br_target = pc4;
    case (bus.alu_opcode_in)
      OPC_OP, OPC_OP_IMM: begin
        alu_wr = 1'b1;
        case (bus.alu_funct3)
          3'b000:  alu_res = (bus.alu_opcode_in == OPC_OP && bus.alu_funct7[5]) ? rs1 - op_b : rs1 + op_b;
          3'b001:  alu_res = rs1 << shamt;
          3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(op_b))};
          3'b011:  alu_res = {{(XLEN-1){1'b0}}, (rs1 < op_b)};
          3'b100:  alu_res = rs1 ^ op_b;
          3'b101:  alu_res = bus.alu_funct7[5] ? $unsigned($signed(rs1) >>> shamt) : rs1 >> shamt;
          3'b110:  alu_res = rs1 | op_b;
          default: alu_res = rs1 & op_b;
        endcase
      end
      OPC_LUI:   begin alu_res = imm;      alu_wr = 1'b1; end
      OPC_AUIPC: begin alu_res = pc + imm; alu_wr = 1'b1; end
      OPC_LOAD:  begin alu_res = rs1 + imm; alu_wr = 1'b1; end
      OPC_STORE: alu_res = rs1 + imm;
      OPC_JAL: begin
        alu_res = pc4; alu_wr = 1'b1; is_br = 1'b1; br_taken = 1'b1;
        br_target = pc + imm;
      end
      OPC_JALR: begin
        alu_res = pc4; alu_wr = 1'b1; is_br = 1'b1; br_taken = 1'b1;
        br_target = (rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
      end
      OPC_BRANCH: begin
        is_br = 1'b1;
        case (bus.alu_funct3)
          F3_BEQ:  br_taken = (rs1 == rs2);
          F3_BNE:  br_taken = (rs1 != rs2);
          F3_BLT:  br_taken = ($signed(rs1) < $signed(rs2));
          F3_BGE:  br_taken = ($signed(rs1) >= $signed(rs2));
          F3_BLTU: br_taken = (rs1 < rs2);
          F3_BGEU: br_taken = (rs1 >= rs2);
          default: br_taken = 1'b0;
        endcase
        br_target = br_taken ? pc + imm : pc4;
      end
      default: ;
    endcase
  end

  // Low 2*XLEN bits of the extended-operand product equal the exact signed/unsigned product
  assign a_sgn    = (bus.alu_funct3 != 3'(MDU_MULHU));
  assign b_sgn    = (bus.alu_funct3 == 3'(MDU_MUL)) || (bus.alu_funct3 == 3'(MDU_MULH));
  assign mul_a    = {{XLEN{a_sgn & rs1[XLEN-1]}}, rs1};
  assign mul_b    = {{XLEN{b_sgn & rs2[XLEN-1]}}, rs2};
  assign mul_prod = mul_a * mul_b;
  assign mul_out  = mul_pipe[MUL_STAGES-1];

  always_ff @(posedge req) begin
    if (reset || bus.flush_in) begin
      mul_vld <= '0;
    end else if (!bus.stall_in) begin
      mul_vld[0] <= mul_go;
      for (int i = 1; i < MUL_STAGES; i++) mul_vld[i] <= mul_vld[i-1];
    end
  end

  always_ff @(posedge req) begin
    if (!bus.stall_in) begin
      if (mul_go) mul_pipe[0] <= mul_prod;
      for (int i = 1; i < MUL_STAGES; i++)
        if (mul_vld[i-1]) mul_pipe[i] <= mul_pipe[i-1];
    end
    if (m_go) begin
      m_op  <= mdu_op_e'(bus.alu_funct3);
      m_rd  <= bus.rd_in;
      m_pc4 <= pc4;
    end
  end

  exec_divider #(.XLEN(XLEN), .DIV_BITS(DIV_BITS)) u_div (
    .clk(req), .rst(reset), .start(div_go), .stall(bus.stall_in), .flush(bus.flush_in),
    .signed_op(~bus.alu_funct3[0]), .dividend(rs1), .divisor(rs2),
    .done(div_done), .quotient(quotient), .remainder(remainder)
  );

  always_comb begin
    case (m_op)
      MDU_MUL:                          m_result = mul_out[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  m_result = mul_out[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:                m_result = quotient;
      default:                          m_result = remainder;
    endcase
  end

  always_ff @(posedge req) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.ready_out = (state == IDLE);
    case (state)
      IDLE:    if (m_go) state_n = bus.alu_funct3[2] ? DIV : MUL;
      MUL:     if (mul_vld[MUL_STAGES-1]) state_n = DONE;
      DIV:     if (div_done) state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (bus.stall_in) state_n = state;
    if (bus.flush_in) state_n = IDLE;
  end

  always_ff @(posedge req) begin
    if (reset) begin
      bus.valid_out        <= 1'b0;
      bus.rd_write         <= 1'b0;
      bus.rd_out           <= '0;
      bus.result_out       <= '0;
      bus.branch_taken_out <= 1'b0;
      bus.branch_pc_out    <= '0;
      bus.mispredict_out   <= 1'b0;
    end else if (bus.flush_in) begin
      bus.valid_out      <= 1'b0;
      bus.rd_write       <= 1'b0;
      bus.mispredict_out <= 1'b0;
    end else if (bus.stall_in) begin
      bus.mispredict_out <= 1'b0;
    end else if (state == DONE) begin
      bus.valid_out        <= 1'b1;
      bus.rd_write         <= (m_rd != 5'd0);
      bus.rd_out           <= m_rd;
      bus.result_out       <= m_result;
      bus.branch_taken_out <= 1'b0;
      bus.branch_pc_out    <= m_pc4;
      bus.mispredict_out   <= 1'b0;
    end else if (accept && is_m) begin
      // Enabled M ops retire later from DONE; disabled ones retire now as a NOP
      bus.valid_out      <= (ENABLE_M == 0);
      bus.rd_write       <= 1'b0;
      bus.mispredict_out <= 1'b0;
      if (ENABLE_M == 0) begin
        bus.rd_out           <= bus.rd_in;
        bus.result_out       <= '0;
        bus.branch_taken_out <= 1'b0;
        bus.branch_pc_out    <= pc4;
      end
    end else if (accept) begin
      bus.valid_out        <= 1'b1;
      bus.rd_write         <= alu_wr && (bus.rd_in != 5'd0);
      bus.rd_out           <= bus.rd_in;
      bus.result_out       <= alu_res;
      bus.branch_taken_out <= br_taken;
      bus.branch_pc_out    <= br_target;
      bus.mispredict_out   <= is_br && (br_taken != bus.branch_predicted_taken_in);
    end else begin
      bus.valid_out      <= 1'b0;
      bus.rd_write       <= 1'b0;
      bus.mispredict_out <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_mdu_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_execute_mdu_stage : directed scoreboard bench for the execute/MDU stage
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_execute_mdu_stage;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] M7     = 7'b0000001;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        wr;
    logic        taken;
    logic [31:0] bpc;
    logic        chk_bpc;
    logic        misp;
  } exp_t;

  logic req, reset;
  int   total = 0, passed = 0, failed = 0, busy_cnt = 0;
  exp_t sb[$];

  execute_mdu_stage_if #(.XLEN(32)) bus ();
  execute_mdu_stage #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(1), .ENABLE_M(1)) dut (
    .req(req), .reset(reset), .bus(bus)
  );

  initial req = 1'b0;
  always #5 req = ~req;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (bus.ready_out === 1'b0) busy_cnt++;
    @(posedge req);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] res, input logic wr,
                          input logic taken, input logic [31:0] bpc, input logic chk_bpc,
                          input logic misp);
    exp_t e;
    e = '{rd: rd, res: res, wr: wr, taken: taken, bpc: bpc, chk_bpc: chk_bpc, misp: misp};
    sb.push_back(e);
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] rd, input logic pred);
    bus.valid_in = 1'b1; bus.stall_in = 1'b0; bus.flush_in = 1'b0;
    bus.alu_opcode_in = op; bus.alu_funct3 = f3; bus.alu_funct7 = f7;
    bus.rs1_value_in = a; bus.rs2_value_in = b; bus.imm_value_in = imm;
    bus.pc_co_in = pc; bus.rd_in = rd; bus.branch_predicted_taken_in = pred;
    @(posedge req);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic retire(input string tag, input int budget);
    exp_t e;
    int   n = 0;
    while (bus.valid_out !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, bus.valid_out, 1'b1);
    e = sb.pop_front();
    check({tag, "_rd"}, bus.rd_out, e.rd);
    check({tag, "_result"}, bus.result_out, e.res);
    check({tag, "_rd_write"}, bus.rd_write, e.wr);
    check({tag, "_taken"}, bus.branch_taken_out, e.taken);
    check({tag, "_mispredict"}, bus.mispredict_out, e.misp);
    if (e.chk_bpc) check({tag, "_branch_pc"}, bus.branch_pc_out, e.bpc);
  endtask

  initial begin
    int stray;
    bus.valid_in = 1'b0; bus.stall_in = 1'b0; bus.flush_in = 1'b0;
    bus.alu_opcode_in = '0; bus.alu_funct3 = '0; bus.alu_funct7 = '0;
    bus.rs1_value_in = '0; bus.rs2_value_in = '0; bus.imm_value_in = '0;
    bus.pc_co_in = '0; bus.rd_in = '0; bus.branch_predicted_taken_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge req);
    #1;
    check("rst_valid", bus.valid_out, 1'b0);
    check("rst_ready", bus.ready_out, 1'b1);
    check("rst_rd_write", bus.rd_write, 1'b0);
    check("rst_result", bus.result_out, 32'h0);
    check("rst_mispredict", bus.mispredict_out, 1'b0);
    check("rst_branch_pc", bus.branch_pc_out, 32'h0);
    reset = 1'b0;

    // ALU ops retire on the edge that accepts them
    push_exp(5'd3, 32'd12, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'h0, 32'h40, 5'd3, 1'b0);
    retire("add", 1);
    push_exp(5'd4, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'h0, 32'h44, 5'd4, 1'b0);
    retire("sub", 1);
    push_exp(5'd0, 32'd6, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OPIMM, 3'b000, 7'b0000000, 32'd5, 32'd0, 32'd1, 32'h48, 5'd0, 1'b0);
    retire("addi_x0", 1);
    push_exp(5'd9, 32'hF800_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OPIMM, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0, 32'h404, 32'h4C, 5'd9, 1'b0);
    retire("srai", 1);

    // Multiplies
    busy_cnt = 0;
    push_exp(5'd10, 32'd1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b011, M7, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h50, 5'd10, 1'b0);
    retire("mulhu", 20);
    check("mulhu_busy_cycles", busy_cnt, 3);
    check("mulhu_ready_after", bus.ready_out, 1'b1);
    push_exp(5'd11, 32'd42, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b000, M7, 32'd6, 32'd7, 32'h0, 32'h54, 5'd11, 1'b0);
    retire("mul", 20);
    push_exp(5'd12, 32'h4000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b001, M7, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h58, 5'd12, 1'b0);
    retire("mulh", 20);
    push_exp(5'd13, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b010, M7, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h5C, 5'd13, 1'b0);
    retire("mulhsu", 20);

    // Divides, including divide-by-zero and signed overflow
    busy_cnt = 0;
    push_exp(5'd14, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b100, M7, 32'd7, 32'd0, 32'h0, 32'h60, 5'd14, 1'b0);
    retire("div_by0", 60);
    check("div_busy_cycles", busy_cnt, 34);
    check("div_ready_after", bus.ready_out, 1'b1);
    push_exp(5'd15, 32'd7, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b110, M7, 32'd7, 32'd0, 32'h0, 32'h64, 5'd15, 1'b0);
    retire("rem_by0", 60);
    push_exp(5'd16, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b100, M7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h68, 5'd16, 1'b0);
    retire("div_ovf", 60);
    push_exp(5'd17, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b110, M7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h6C, 5'd17, 1'b0);
    retire("rem_ovf", 60);
    push_exp(5'd18, 32'hFFFF_FFFD, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b100, M7, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h70, 5'd18, 1'b0);
    retire("div_neg", 60);
    push_exp(5'd19, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b110, M7, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h74, 5'd19, 1'b0);
    retire("rem_neg", 60);

    // Branches and jumps
    push_exp(5'd9, 32'h0, 1'b0, 1'b1, 32'h110, 1'b1, 1'b1);
    issue(BRANCH, 3'b000, 7'b0, 32'd4, 32'd4, 32'd16, 32'h100, 5'd9, 1'b0);
    retire("beq", 1);
    tick();
    check("beq_misp_pulse_end", bus.mispredict_out, 1'b0);
    push_exp(5'd0, 32'h0, 1'b0, 1'b0, 32'h104, 1'b1, 1'b1);
    issue(BRANCH, 3'b001, 7'b0, 32'd4, 32'd4, 32'd16, 32'h100, 5'd0, 1'b1);
    retire("bne", 1);
    bus.stall_in = 1'b1;
    tick();
    check("stall_misp_cleared", bus.mispredict_out, 1'b0);
    check("stall_valid_held", bus.valid_out, 1'b1);
    check("stall_bpc_held", bus.branch_pc_out, 32'h104);
    bus.stall_in = 1'b0;
    push_exp(5'd1, 32'h204, 1'b1, 1'b1, 32'h220, 1'b1, 1'b0);
    issue(JAL, 3'b000, 7'b0, 32'h0, 32'h0, 32'h20, 32'h200, 5'd1, 1'b1);
    retire("jal", 1);
    push_exp(5'd2, 32'h304, 1'b1, 1'b1, 32'h304, 1'b1, 1'b0);
    issue(JALR, 3'b000, 7'b0, 32'h301, 32'h0, 32'd4, 32'h300, 5'd2, 1'b1);
    retire("jalr", 1);

    // Flush a divide mid-iteration; its result must never appear
    issue(OP, 3'b101, M7, 32'd100, 32'd7, 32'h0, 32'h80, 5'd6, 1'b0);
    repeat (10) tick();
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    check("flush_valid", bus.valid_out, 1'b0);
    check("flush_ready", bus.ready_out, 1'b1);
    check("flush_rd_write", bus.rd_write, 1'b0);
    push_exp(5'd7, 32'd42, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b000, 7'b0, 32'd20, 32'd22, 32'h0, 32'h84, 5'd7, 1'b0);
    retire("add_after_flush", 1);
    stray = 0;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (bus.valid_out === 1'b1) stray++;
      tick();
    end
    check("flush_no_stale_result", stray, 0);

    // Stall during a divide pushes completion out by the stall length
    push_exp(5'd5, 32'd3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b000, 7'b0, 32'd1, 32'd2, 32'h0, 32'h90, 5'd5, 1'b0);
    retire("add_pre_stall", 1);
    busy_cnt = 0;
    push_exp(5'd8, 32'd14, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(OP, 3'b101, M7, 32'd100, 32'd7, 32'h0, 32'h94, 5'd8, 1'b0);
    repeat (4) tick();
    bus.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_result_stable", bus.result_out, 32'd3);
      check("stall_valid_low", bus.valid_out, 1'b0);
    end
    bus.stall_in = 1'b0;
    retire("divu_stalled", 60);
    check("divu_stall_busy_cycles", busy_cnt, 37);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
